pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage MIPS core with precise exceptions. It replaces the per-stage hand-written D/E, E/M and M/W registers with one configurable block. It carries PC, instruction, destination register, branch-delay flag, exception code and an opaque payload. It also supports hold, bubble, interrupt/exception redirect, exception-code merging and saturating stall/bubble statistics.

---
 rtl/pipe_stage_reg.sv | 100 ++++++++++
 tb/tb_pipe_stage_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: hold, bubble, exception redirect,
// exception-code merging and saturating stall/bubble statistics.
module pipe_stage_reg #(
    parameter int unsigned DATA_W      = 96,
    parameter int unsigned CODE_W      = 5,
    parameter logic [31:0] HANDLER_PC  = 32'h0000_4180,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          KILL_ON_EXC = 1'b1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              req_i,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [4:0]        in_regwrite,
    input  logic              in_bd,
    input  logic [CODE_W-1:0] in_code,
    input  logic [CODE_W-1:0] new_code,
    input  logic [DATA_W-1:0] in_payload,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [4:0]        out_regwrite,
    output logic              out_bd,
    output logic [CODE_W-1:0] out_code,
    output logic [DATA_W-1:0] out_payload,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [CODE_W-1:0] merged_code;
    logic              kill;
    logic              stall_take;
    logic              bubble_take;

    // Oldest exception wins; decide whether the loaded instruction is squashed.
    always_comb begin
        merged_code = (in_code != '0) ? in_code : new_code;
        kill        = KILL_ON_EXC && (merged_code != '0);
        bubble_take = req_i || flush_i;
        stall_take  = stall_i && !bubble_take;
    end

    // Stage contents: req_i > flush_i > stall_i > load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_pc       <= RESET_PC;
            out_instr    <= '0;
            out_regwrite <= '0;
            out_bd       <= 1'b0;
            out_code     <= '0;
            out_payload  <= '0;
        end else if (req_i) begin
            out_valid    <= 1'b0;
            out_pc       <= HANDLER_PC;
            out_instr    <= '0;
            out_regwrite <= '0;
            out_bd       <= 1'b0;
            out_code     <= '0;
            out_payload  <= '0;
        end else if (flush_i) begin
            // Bubble keeps PC/BD so a later stage can still report EPC and BD.
            out_valid    <= 1'b0;
            out_pc       <= in_pc;
            out_instr    <= '0;
            out_regwrite <= '0;
            out_bd       <= in_bd;
            out_code     <= '0;
            out_payload  <= '0;
        end else if (!stall_i) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_instr    <= kill ? 32'h0 : in_instr;
            out_regwrite <= kill ? 5'h0 : in_regwrite;
            out_bd       <= in_bd;
            out_code     <= merged_code;
            out_payload  <= in_payload;
        end
    end

    // Saturating statistics counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_take && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bubble_take && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (default, no-kill, 2-bit counters)
// share one stimulus stream and are compared to a behavioural model.
module tb_pipe_stage_reg;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rw;
        logic        bd;
        logic [4:0]  code;
        logic [95:0] pl;
        logic [31:0] sc;
        logic [31:0] bc;
    } st_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0, flush_i = 1'b0, req_i = 1'b0;
    logic [31:0] in_pc = '0, in_instr = '0;
    logic [4:0]  in_regwrite = '0;
    logic        in_bd = 1'b0;
    logic [4:0]  in_code = '0, new_code = '0;
    logic [95:0] in_payload = '0;

    logic        o0_valid, o1_valid, o2_valid;
    logic [31:0] o0_pc, o1_pc, o2_pc, o0_instr, o1_instr, o2_instr;
    logic [4:0]  o0_rw, o1_rw, o2_rw, o0_code, o1_code, o2_code;
    logic        o0_bd, o1_bd, o2_bd;
    logic [95:0] o0_pl, o1_pl, o2_pl;
    logic [15:0] o0_sc, o0_bc, o1_sc, o1_bc;
    logic [1:0]  o2_sc, o2_bc;

    int checks = 0;
    int errors = 0;
    st_t m0, m1, m2;

    always #5 clk = ~clk;

    pipe_stage_reg dut0 (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .req_i(req_i),
        .in_pc(in_pc), .in_instr(in_instr), .in_regwrite(in_regwrite), .in_bd(in_bd),
        .in_code(in_code), .new_code(new_code), .in_payload(in_payload),
        .out_valid(o0_valid), .out_pc(o0_pc), .out_instr(o0_instr), .out_regwrite(o0_rw),
        .out_bd(o0_bd), .out_code(o0_code), .out_payload(o0_pl),
        .stall_cnt(o0_sc), .bubble_cnt(o0_bc)
    );

    pipe_stage_reg #(.KILL_ON_EXC(1'b0)) dut1 (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .req_i(req_i),
        .in_pc(in_pc), .in_instr(in_instr), .in_regwrite(in_regwrite), .in_bd(in_bd),
        .in_code(in_code), .new_code(new_code), .in_payload(in_payload),
        .out_valid(o1_valid), .out_pc(o1_pc), .out_instr(o1_instr), .out_regwrite(o1_rw),
        .out_bd(o1_bd), .out_code(o1_code), .out_payload(o1_pl),
        .stall_cnt(o1_sc), .bubble_cnt(o1_bc)
    );

    pipe_stage_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .req_i(req_i),
        .in_pc(in_pc), .in_instr(in_instr), .in_regwrite(in_regwrite), .in_bd(in_bd),
        .in_code(in_code), .new_code(new_code), .in_payload(in_payload),
        .out_valid(o2_valid), .out_pc(o2_pc), .out_instr(o2_instr), .out_regwrite(o2_rw),
        .out_bd(o2_bd), .out_code(o2_code), .out_payload(o2_pl),
        .stall_cnt(o2_sc), .bubble_cnt(o2_bc)
    );

    function automatic st_t m_reset();
        st_t s;
        s.valid = 1'b0; s.pc = 32'h0; s.instr = '0; s.rw = '0; s.bd = 1'b0;
        s.code = '0; s.pl = '0; s.sc = 0; s.bc = 0;
        return s;
    endfunction

    // One clock edge of the stage as described by its action priority list.
    function automatic st_t m_next(st_t s, bit kill_en, logic [31:0] cmax);
        st_t n = s;
        logic [4:0] code;
        if (req_i || flush_i) begin
            n.valid = 1'b0; n.instr = '0; n.rw = '0; n.code = '0; n.pl = '0;
            n.pc = req_i ? 32'h0000_4180 : in_pc;
            n.bd = req_i ? 1'b0 : in_bd;
            if (s.bc < cmax) n.bc = s.bc + 1;
        end else if (stall_i) begin
            if (s.sc < cmax) n.sc = s.sc + 1;
        end else begin
            code = (in_code != 0) ? in_code : new_code;
            n.valid = 1'b1; n.pc = in_pc; n.bd = in_bd; n.pl = in_payload; n.code = code;
            if (kill_en && code != 0) begin
                n.instr = '0; n.rw = '0;
            end else begin
                n.instr = in_instr; n.rw = in_regwrite;
            end
        end
        return n;
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("d0_valid", 128'(o0_valid), 128'(m0.valid));
        chk("d0_pc", 128'(o0_pc), 128'(m0.pc));
        chk("d0_instr", 128'(o0_instr), 128'(m0.instr));
        chk("d0_rw", 128'(o0_rw), 128'(m0.rw));
        chk("d0_bd", 128'(o0_bd), 128'(m0.bd));
        chk("d0_code", 128'(o0_code), 128'(m0.code));
        chk("d0_payload", 128'(o0_pl), 128'(m0.pl));
        chk("d0_stall_cnt", 128'(o0_sc), 128'(m0.sc));
        chk("d0_bubble_cnt", 128'(o0_bc), 128'(m0.bc));
        chk("d1_valid", 128'(o1_valid), 128'(m1.valid));
        chk("d1_pc", 128'(o1_pc), 128'(m1.pc));
        chk("d1_instr", 128'(o1_instr), 128'(m1.instr));
        chk("d1_rw", 128'(o1_rw), 128'(m1.rw));
        chk("d1_code", 128'(o1_code), 128'(m1.code));
        chk("d2_valid", 128'(o2_valid), 128'(m2.valid));
        chk("d2_pc", 128'(o2_pc), 128'(m2.pc));
        chk("d2_stall_cnt", 128'(o2_sc), 128'(m2.sc));
        chk("d2_bubble_cnt", 128'(o2_bc), 128'(m2.bc));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            m0 = m_reset(); m1 = m_reset(); m2 = m_reset();
        end else begin
            m0 = m_next(m0, 1'b1, 32'hFFFF);
            m1 = m_next(m1, 1'b0, 32'hFFFF);
            m2 = m_next(m2, 1'b1, 32'h3);
        end
        #1;
        check_all();
    endtask

    task automatic set_ctl(logic r, logic f, logic s);
        req_i = r; flush_i = f; stall_i = s;
    endtask

    task automatic set_in(logic [31:0] pc, logic [31:0] ins, logic [4:0] rw, logic bd,
                          logic [4:0] ic, logic [4:0] nc);
        in_pc = pc; in_instr = ins; in_regwrite = rw; in_bd = bd;
        in_code = ic; new_code = nc; in_payload = {$urandom, $urandom, $urandom};
    endtask

    initial begin
        m0 = m_reset(); m1 = m_reset(); m2 = m_reset();
        #3;
        check_all();
        // Release between edges; the first edge afterwards does the load.
        @(negedge clk);
        reset = 1'b1;
        set_ctl(0, 0, 0);
        set_in(32'h3004, 32'h2401_0001, 5'd1, 1'b0, 5'd0, 5'd0);
        tick();
        chk("first_load_valid", 128'(o0_valid), 128'(1'b1));
        chk("first_load_pc", 128'(o0_pc), 128'(32'h3004));

        // Code merge: new code alone, then older upstream code wins.
        set_in(32'h3008, 32'h0000_0020, 5'd3, 1'b0, 5'd0, 5'd4);
        tick();
        chk("merge_new_code", 128'(o0_code), 128'(5'd4));
        chk("merge_kill_instr", 128'(o0_instr), 128'(32'h0));
        chk("nokill_instr", 128'(o1_instr), 128'(32'h0000_0020));
        set_in(32'h300c, 32'h0000_0020, 5'd3, 1'b0, 5'd12, 5'd4);
        tick();
        chk("merge_old_code", 128'(o0_code), 128'(5'd12));
        chk("nokill_rw", 128'(o1_rw), 128'(5'd3));

        // req_i beats flush_i and stall_i.
        set_ctl(1, 1, 1);
        set_in(32'h3010, 32'h1234_5678, 5'd7, 1'b1, 5'd0, 5'd0);
        tick();
        chk("req_pc", 128'(o0_pc), 128'(32'h4180));
        chk("req_bubble_cnt", 128'(o0_bc), 128'(16'd1));
        chk("req_stall_cnt", 128'(o0_sc), 128'(16'd0));

        // Flush bubble keeps PC/BD.
        set_ctl(0, 1, 0);
        set_in(32'h3020, 32'h1234_5678, 5'd5, 1'b1, 5'd0, 5'd0);
        tick();
        chk("flush_pc", 128'(o0_pc), 128'(32'h3020));
        chk("flush_bd", 128'(o0_bd), 128'(1'b1));

        // Stall hold for 3 edges, then load on release.
        set_ctl(0, 0, 0);
        set_in(32'h3000, 32'h2401_0002, 5'd2, 1'b0, 5'd0, 5'd0);
        tick();
        set_ctl(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            set_in(32'h3100 + 32'(i * 4), $urandom, 5'd9, 1'b0, 5'd0, 5'd0);
            tick();
        end
        chk("stall_hold_pc", 128'(o0_pc), 128'(32'h3000));
        chk("stall_cnt3", 128'(o0_sc), 128'(16'd3));
        set_ctl(0, 0, 0);
        set_in(32'h3200, 32'h2401_0003, 5'd4, 1'b0, 5'd0, 5'd0);
        tick();
        chk("stall_release_pc", 128'(o0_pc), 128'(32'h3200));

        // Saturation of the 2-bit counters.
        set_ctl(0, 0, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_stall_cnt", 128'(o2_sc), 128'(2'd3));
        set_ctl(0, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_bubble_cnt", 128'(o2_bc), 128'(2'd3));

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            set_ctl(($urandom % 8) == 0, ($urandom % 6) == 0, ($urandom % 3) == 0);
            set_in($urandom, $urandom, 5'($urandom), 1'($urandom),
                   (($urandom % 3) == 0) ? 5'($urandom) : 5'd0,
                   (($urandom % 3) == 0) ? 5'($urandom) : 5'd0);
            tick();
        end

        // Asynchronous reset mid-stall takes effect immediately.
        set_ctl(0, 0, 1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        m0 = m_reset(); m1 = m_reset(); m2 = m_reset();
        check_all();
        chk("async_rst_stall_cnt", 128'(o0_sc), 128'(16'd0));
        tick();
        @(negedge clk);
        reset = 1'b1;
        set_ctl(0, 0, 0);
        set_in(32'h3300, 32'h2401_0004, 5'd6, 1'b0, 5'd0, 5'd0);
        tick();
        chk("post_reset_pc", 128'(o0_pc), 128'(32'h3300));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
